// File: rtl/mm_operand_bridge.sv
// -----------------------------------------------------------------------------
// mm_operand_bridge
//
// Operand/result bridge between a single-port BRAM and an external FIOS
// Montgomery core. For each operation it reads p'_0, p, a and b into operand
// registers, pulses core_start_o, serves the core's a_shift / b_fetch /
// p_fetch / res_push requests, then writes the S result words back to BRAM.
//
// BRAM word map (LS word first):
//   0 = p'_0, 1..S = p, S+1..2S = a, 2S+1..3S = b, 3S+1..4S = result
//
// Optional feature: define MM_BRIDGE_PERF_EN to build the 32-bit saturating
// operation cycle counter behind perf_cycles_o; otherwise it reads 0.
//
// Ports
//   clock_i, reset_ni       clock, asynchronous active-low reset
//   start_i, keep_mod_i     operation request; keep_mod skips p'_0/p reload
//   BRAM_*                  BRAM data in/out, write enable, enable, address
//   core_start_o            one-cycle start pulse to the core
//   core_p_prime_0_o        p'_0 operand
//   core_a_o / b_o / p_o    low words of the a, b and p operand registers
//   core_a_shift_i          drop PE_NB a-words, zero fill from the top
//   core_b_fetch_i          rotate b right by one word
//   core_p_fetch_i          rotate p right by one word
//   core_res_push_i/res_i   result word shifted into the result register
//   core_done_i             core finished, start write-back
//   busy_o, done_o, err_o   status; err_o = wrong number of result pushes
//   perf_cycles_o           cycles of the last operation
// -----------------------------------------------------------------------------
module mm_operand_bridge #(
  parameter int W      = 17,
  parameter int S      = 8,
  parameter int PE_NB  = 3,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = $clog2(4*S+1)
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  input  logic                start_i,
  input  logic                keep_mod_i,
  input  logic [W-1:0]        BRAM_dout_i,
  output logic [W-1:0]        BRAM_din_o,
  output logic                BRAM_we_o,
  output logic                BRAM_en_o,
  output logic [31:0]         BRAM_addr_o,
  output logic                core_start_o,
  output logic [W-1:0]        core_p_prime_0_o,
  output logic [PE_NB*W-1:0]  core_a_o,
  output logic [W-1:0]        core_b_o,
  output logic [W-1:0]        core_p_o,
  input  logic                core_a_shift_i,
  input  logic                core_b_fetch_i,
  input  logic                core_p_fetch_i,
  input  logic                core_res_push_i,
  input  logic [W-1:0]        core_res_i,
  input  logic                core_done_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [31:0]         perf_cycles_o
);

  localparam int OPW = S*W;
  localparam int PCW = $clog2(S+2);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_LOAD_PP = 4'd1;
  localparam logic [3:0] ST_LOAD_P  = 4'd2;
  localparam logic [3:0] ST_LOAD_A  = 4'd3;
  localparam logic [3:0] ST_LOAD_B  = 4'd4;
  localparam logic [3:0] ST_DRAIN   = 4'd5;
  localparam logic [3:0] ST_RUN     = 4'd6;
  localparam logic [3:0] ST_WRITE   = 4'd7;
  localparam logic [3:0] ST_DONE    = 4'd8;

  localparam logic [1:0] SEL_PP = 2'd0;
  localparam logic [1:0] SEL_P  = 2'd1;
  localparam logic [1:0] SEL_A  = 2'd2;
  localparam logic [1:0] SEL_B  = 2'd3;

  localparam logic [ADDR_W-1:0] ADR_P_LAST  = ADDR_W'(S);
  localparam logic [ADDR_W-1:0] ADR_A_FIRST = ADDR_W'(S+1);
  localparam logic [ADDR_W-1:0] ADR_A_LAST  = ADDR_W'(2*S);
  localparam logic [ADDR_W-1:0] ADR_B_LAST  = ADDR_W'(3*S);
  localparam logic [ADDR_W-1:0] ADR_R_LAST  = ADDR_W'(4*S);
  localparam logic [1:0]        DRAIN_LAST  = 2'(RD_LAT);
  localparam logic [PCW-1:0]    PC_FULL     = PCW'(S);
  localparam logic [PCW-1:0]    PC_SAT      = PCW'(S+1);

  // Insert a word at the MS end of an operand, dropping the LS word.
  function automatic logic [OPW-1:0] shift_in(input logic [OPW-1:0] r,
                                              input logic [W-1:0]   w);
    logic [OPW-1:0] top;
    top = '0;
    top[OPW-1 -: W] = w;
    return (r >> W) | top;
  endfunction

  // Rotate an operand right by one word (LS word wraps to the MS end).
  function automatic logic [OPW-1:0] rot_right(input logic [OPW-1:0] r);
    return (r >> W) | (r << (OPW-W));
  endfunction

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic [PCW-1:0]    pcnt_q, pcnt_d, pc_next;
  logic              err_q, err_d;
  logic              cstart_q, cstart_d;
  logic [RD_LAT:0]       tvld_q, tvld_d;
  logic [RD_LAT:0][1:0]  tsel_q, tsel_d;
  logic [W-1:0]      din_q, din_d;
  logic [W-1:0]      pp_q, pp_d;
  logic [OPW-1:0]    p_q, p_d;
  logic [OPW-1:0]    a_q, a_d;
  logic [OPW-1:0]    b_q, b_d;
  logic [OPW-1:0]    res_q, res_d;
  logic              rd_en;
  logic [1:0]        rd_sel;

  // Read issue: every load state issues one read per cycle.
  always_comb begin
    rd_en  = 1'b1;
    rd_sel = SEL_PP;
    case (state_q)
      ST_LOAD_PP: rd_sel = SEL_PP;
      ST_LOAD_P:  rd_sel = SEL_P;
      ST_LOAD_A:  rd_sel = SEL_A;
      ST_LOAD_B:  rd_sel = SEL_B;
      default:    rd_en  = 1'b0;
    endcase
  end

  // Control FSM
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    dcnt_d   = dcnt_q;
    pcnt_d   = pcnt_q;
    err_d    = err_q;
    cstart_d = 1'b0;
    pc_next  = (core_res_push_i && (pcnt_q != PC_SAT)) ? pcnt_q + PCW'(1) : pcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          err_d  = 1'b0;
          pcnt_d = '0;
          if (keep_mod_i) begin
            state_d = ST_LOAD_A;
            addr_d  = ADR_A_FIRST;
          end else begin
            state_d = ST_LOAD_PP;
            addr_d  = '0;
          end
        end
      end
      ST_LOAD_PP: begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ST_LOAD_P;
      end
      ST_LOAD_P: begin
        addr_d = addr_q + ADDR_W'(1);
        if (addr_q == ADR_P_LAST) state_d = ST_LOAD_A;
      end
      ST_LOAD_A: begin
        addr_d = addr_q + ADDR_W'(1);
        if (addr_q == ADR_A_LAST) state_d = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        // addr leaves this state at 3S+1, the first result address.
        addr_d = addr_q + ADDR_W'(1);
        if (addr_q == ADR_B_LAST) begin
          state_d = ST_DRAIN;
          dcnt_d  = '0;
        end
      end
      ST_DRAIN: begin
        dcnt_d = dcnt_q + 2'd1;
        if (dcnt_q == DRAIN_LAST) begin
          state_d  = ST_RUN;
          cstart_d = 1'b1;
        end
      end
      ST_RUN: begin
        pcnt_d = pc_next;
        if (core_done_i) begin
          state_d = ST_WRITE;
          if (pc_next != PC_FULL) err_d = 1'b1;
        end
      end
      ST_WRITE: begin
        if (addr_q == ADR_R_LAST) state_d = ST_DONE;
        else                      addr_d  = addr_q + ADDR_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read tag delay line and operand datapath
  always_comb begin
    tvld_d    = tvld_q;
    tsel_d    = tsel_q;
    tvld_d[0] = rd_en;
    tsel_d[0] = rd_sel;
    for (int i = 1; i <= RD_LAT; i++) begin
      tvld_d[i] = tvld_q[i-1];
      tsel_d[i] = tsel_q[i-1];
    end

    din_d = BRAM_dout_i;
    pp_d  = pp_q;
    p_d   = p_q;
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;

    // din_q holds the word for the read issued RD_LAT+1 cycles ago.
    if (tvld_q[RD_LAT]) begin
      case (tsel_q[RD_LAT])
        SEL_PP:  pp_d = din_q;
        SEL_P:   p_d  = shift_in(p_q, din_q);
        SEL_A:   a_d  = shift_in(a_q, din_q);
        default: b_d  = shift_in(b_q, din_q);
      endcase
    end

    if (state_q == ST_RUN) begin
      if (core_a_shift_i)  a_d   = a_q >> (PE_NB*W);
      if (core_b_fetch_i)  b_d   = rot_right(b_q);
      if (core_p_fetch_i)  p_d   = rot_right(p_q);
      if (core_res_push_i) res_d = shift_in(res_q, core_res_i);
    end

    if (state_q == ST_WRITE) res_d = res_q >> W;
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      dcnt_q   <= '0;
      pcnt_q   <= '0;
      err_q    <= 1'b0;
      cstart_q <= 1'b0;
      tvld_q   <= '0;
      tsel_q   <= '0;
      din_q    <= '0;
      pp_q     <= '0;
      p_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dcnt_q   <= dcnt_d;
      pcnt_q   <= pcnt_d;
      err_q    <= err_d;
      cstart_q <= cstart_d;
      tvld_q   <= tvld_d;
      tsel_q   <= tsel_d;
      din_q    <= din_d;
      pp_q     <= pp_d;
      p_q      <= p_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
    end
  end

`ifdef MM_BRIDGE_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;
  logic [31:0] perf_q, perf_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Counter is zeroed in the accepting cycle; the latched value includes DONE.
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    perf_d     = perf_q;
    if (state_q == ST_IDLE) begin
      if (start_i) perf_cnt_d = '0;
    end else begin
      perf_cnt_d = sat_inc(perf_cnt_q);
    end
    if (state_q == ST_DONE) perf_d = sat_inc(perf_cnt_q);
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      perf_cnt_q <= '0;
      perf_q     <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
      perf_q     <= perf_d;
    end
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

  assign BRAM_en_o        = rd_en | (state_q == ST_WRITE);
  assign BRAM_we_o        = (state_q == ST_WRITE);
  assign BRAM_addr_o      = BRAM_en_o ? 32'(addr_q) : 32'd0;
  assign BRAM_din_o       = res_q[W-1:0];
  assign core_start_o     = cstart_q;
  assign core_p_prime_0_o = pp_q;
  assign core_a_o         = a_q[PE_NB*W-1:0];
  assign core_b_o         = b_q[W-1:0];
  assign core_p_o         = p_q[W-1:0];
  assign busy_o           = (state_q != ST_IDLE);
  assign done_o           = (state_q == ST_DONE);
  assign err_o            = err_q;

endmodule
